// File: rtl/serial_addsub_pkg.sv
// ============================================================================
//  Module   : serial_addsub_pkg
//  Brief    : Shared state encodings and constant helpers for multi-cycle
//             arithmetic blocks.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for n steps; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_addsub_fa.sv
// ============================================================================
//  Module   : serial_addsub_fa
//  Brief    : Single-bit full adder cell used to build the carry chain.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_addsub_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_p;

  assign w_p = a ^ b;
  assign s   = w_p ^ ci;
  assign co  = (a & b) | (ci & w_p);

endmodule

`default_nettype wire

// File: rtl/serial_addsub.sv
// ============================================================================
//  Module   : serial_addsub
//  Brief    : Multi-cycle add/subtract, STEP bits per clock, LSB chunk first.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int STEPS = WIDTH / STEP;
  localparam int CW    = clog2_min1(STEPS);

  if (WIDTH < 2 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_param_check
    $error("serial_addsub: WIDTH must be >= 2 and divisible by STEP");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_co;
  logic             r_ovf;
  logic [CW-1:0]    r_cnt;

  logic [STEP:0]         w_c;
  logic [STEP-1:0]       w_s;
  logic [WIDTH+STEP-1:0] w_sum_cat;
  logic                  w_accept;
  logic                  w_last;

  assign w_c[0] = r_carry;

  for (genvar i = 0; i < STEP; i++) begin : g_chain
    serial_addsub_fa u_fa (
      .a  (r_a[i]),
      .b  (r_b[i]),
      .ci (w_c[i]),
      .s  (w_s[i]),
      .co (w_c[i+1])
    );
  end

  // New chunk enters at the top; the concatenation also covers STEP == WIDTH.
  assign w_sum_cat = {w_s, r_sum};
  assign w_accept  = start && (r_state == IDLE || r_state == DONE);
  assign w_last    = (r_state == RUN) && (r_cnt == CW'(STEPS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = RUN;
      RUN:     if (w_last)   w_state_nxt = DONE;
      DONE:    w_state_nxt = w_accept ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      // Subtract is a + ~b + 1, so invert B and force the carry here.
      r_a     <= a;
      r_b     <= op ? ~b : b;
      r_carry <= op ? 1'b1 : ci;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> STEP;
      r_b     <= r_b >> STEP;
      r_sum   <= w_sum_cat[WIDTH+STEP-1:STEP];
      r_carry <= w_c[STEP];
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_co  <= w_c[STEP];
        r_ovf <= w_c[STEP-1] ^ w_c[STEP];
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign co   = r_co;
  assign ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_addsub.sv
// ============================================================================
//  Module   : tb_serial_addsub
//  Brief    : Directed self-checking bench for serial_addsub (STEP=1 and 4).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_addsub;

  logic       clk;
  logic       rst_n;

  logic       start1, op1, ci1;
  logic [7:0] a1, b1;
  logic       busy1, done1, co1, ovf1;
  logic [7:0] sum1;

  logic       start4, op4, ci4;
  logic [7:0] a4, b4;
  logic       busy4, done4, co4, ovf4;
  logic [7:0] sum4;

  int n_cmp;
  int n_bad;

  serial_addsub #(.WIDTH(8), .STEP(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op(op1), .a(a1), .b(b1), .ci(ci1),
    .busy(busy1), .done(done1), .sum(sum1), .co(co1), .ovf(ovf1)
  );

  serial_addsub #(.WIDTH(8), .STEP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .op(op4), .a(a4), .b(b4), .ci(ci4),
    .busy(busy4), .done(done4), .sum(sum4), .co(co4), .ovf(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one STEP=1 operation, count busy cycles up to done, check results.
  task automatic run1(input string tag, input logic o, input logic [7:0] aa,
                      input logic [7:0] bb, input logic cc, input logic [7:0] es,
                      input logic eco, input logic eovf);
    int nbusy;
    start1 = 1'b1; op1 = o; a1 = aa; b1 = bb; ci1 = cc;
    step();
    start1 = 1'b0;
    nbusy = 0;
    while (done1 !== 1'b1 && nbusy < 20) begin
      if (busy1 === 1'b1) nbusy++;
      step();
    end
    check({tag, "_busy_cycles"}, nbusy, 8);
    check({tag, "_done"}, {31'd0, done1}, 1);
    check({tag, "_busy_at_done"}, {31'd0, busy1}, 0);
    check({tag, "_sum"}, {24'd0, sum1}, {24'd0, es});
    check({tag, "_co"}, {31'd0, co1}, {31'd0, eco});
    check({tag, "_ovf"}, {31'd0, ovf1}, {31'd0, eovf});
    step();
    check({tag, "_done_pulse_end"}, {31'd0, done1}, 0);
    check({tag, "_sum_hold"}, {24'd0, sum1}, {24'd0, es});
  endtask

  initial begin
    int n;
    int seen;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    start1 = 1'b0; op1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;
    start4 = 1'b0; op4 = 1'b0; a4 = '0; b4 = '0; ci4 = 1'b0;
    #2;
    check("rst_outputs1", {busy1, done1, co1, ovf1, sum1}, 0);
    check("rst_outputs4", {busy4, done4, co4, ovf4, sum4}, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Add and subtract vectors on the bit-serial instance.
    run1("add_0f_01", 1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    run1("add_ff_01", 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run1("add_7f_ci", 1'b0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);
    run1("sub_05_07", 1'b1, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    run1("sub_80_01", 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);

    // Four-bit chunks: done two cycles after accept, then back-to-back start.
    start4 = 1'b1; op4 = 1'b0; a4 = 8'hA5; b4 = 8'h5B; ci4 = 1'b0;
    step();
    start4 = 1'b0;
    check("s4_busy_c1", {30'd0, busy4, done4}, 32'h2);
    step();
    check("s4_busy_c2", {30'd0, busy4, done4}, 32'h2);
    step();
    check("s4_done", {30'd0, busy4, done4}, 32'h1);
    check("s4_sum", {24'd0, sum4}, 32'h00);
    check("s4_co", {31'd0, co4}, 1);
    check("s4_ovf", {31'd0, ovf4}, 0);
    start4 = 1'b1; a4 = 8'h01; b4 = 8'h01;
    step();
    start4 = 1'b0; a4 = 8'hEE; b4 = 8'hEE;
    check("s4_b2b_busy", {30'd0, busy4, done4}, 32'h2);
    step();
    step();
    check("s4_b2b_done", {31'd0, done4}, 1);
    check("s4_b2b_sum", {24'd0, sum4}, 32'h02);
    check("s4_b2b_co", {31'd0, co4}, 0);

    // Start during RUN must be ignored.
    start1 = 1'b1; op1 = 1'b0; a1 = 8'h3C; b1 = 8'h21; ci1 = 1'b0;
    step();
    start1 = 1'b0;
    step();
    step();
    start1 = 1'b1; op1 = 1'b1; a1 = 8'hFF; b1 = 8'hFF; ci1 = 1'b1;
    step();
    start1 = 1'b0;
    check("ign_busy", {31'd0, busy1}, 1);
    n = 0;
    while (done1 !== 1'b1 && n < 20) begin
      n++;
      step();
    end
    check("ign_done_time", n, 5);
    check("ign_sum", {24'd0, sum1}, 32'h5D);
    check("ign_co_ovf", {30'd0, co1, ovf1}, 0);
    step();

    // Reset in the fourth RUN cycle aborts at once.
    start1 = 1'b1; op1 = 1'b0; a1 = 8'h12; b1 = 8'h34; ci1 = 1'b0;
    step();
    start1 = 1'b0;
    step();
    step();
    step();
    check("mid_busy", {31'd0, busy1}, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", {busy1, done1, co1, ovf1, sum1}, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done1 !== 1'b0) seen++;
    end
    check("mid_rst_no_done", seen, 0);
    start1 = 1'b1;
    rst_n = 1'b1;
    run1("post_rst", 1'b0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised multi-cycle add/subtract unit; successor to the single-bit full adder.
- Latches two WIDTH-bit operands on a start strobe and processes them STEP bits per clock, LSB chunk first, through a chain of STEP full-adder cells.
- Reports sum, carry-out and signed overflow with a busy/done handshake.
- Sits between a register-file style operand source and any consumer that can wait WIDTH/STEP cycles.

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥ 2.
- STEP, 1, bits processed per clock; must divide WIDTH exactly. Elaboration error otherwise.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request strobe; sampled only when ready to accept.
- op  input  1  mode, latched with start. 0 = add (a + b + ci), 1 = subtract (a - b, computed as a + ~b + 1; ci ignored).
- a  input  WIDTH  operand A, latched on accepted start.
- b  input  WIDTH  operand B, latched on accepted start.
- ci  input  1  carry-in for add, latched on accepted start.
- busy  output  1  high while a computation is in progress.
- done  output  1  one-cycle pulse when sum/co/ovf become valid.
- sum  output  WIDTH  result; held stable from done until the next accepted start.
- co  output  1  carry-out of MSB. In subtract mode co=1 means no borrow (a ≥ b, unsigned).
- ovf  output  1  signed two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Constants: STEPS = WIDTH/STEP. Counter width = clog2(STEPS), minimum 1.
- States:
  - IDLE: waiting.
  - RUN: processing chunks.
  - DONE: single cycle, done=1.
- Reset (rst_n low, asynchronous): state=IDLE; busy, done, sum, co and ovf all 0; counter=0; internal operand and carry registers=0.
- Accept rule: start is accepted at a rising edge where state is IDLE or DONE.
  - Start while in RUN is ignored: no latch, no restart, no error.
- On accept:
  - Latch a into operand register A.
  - Latch b into operand register B, or ~b when op=1.
  - Latch carry as ci (op=0) or 1 (op=1).
  - Counter=0; state to RUN.
  - Next cycle: busy=1, done=0.
  - sum/co/ovf are not cleared at accept. They hold stale values until overwritten and are meaningful only at done.
- RUN, each edge:
  - The STEP-bit chain adds the low STEP bits of A and B plus the carry register.
  - Result chunk shifts into the top of the sum shift register (sum shifts right by STEP). A and B shift right by STEP.
  - Carry register takes the chain's carry-out; counter increments.
  - On the edge where counter == STEPS-1:
    - Capture co = chain carry-out.
    - Capture ovf = chain carry-into-MSB XOR carry-out.
    - State to DONE.
- Latency: with start accepted at edge E0, done is high during the cycle following edge E_STEPS; busy is high for exactly STEPS cycles.
- DONE: done=1, busy=0 for one cycle.
  - Next edge: IDLE if no start; RUN if start is accepted, back-to-back with zero bubble.
- Edge cases:
  - Single chunk (STEP == WIDTH): STEPS=1; done follows one RUN cycle.
  - Operand inputs changing during RUN have no effect.
  - Reset asserted mid-RUN aborts immediately: outputs go to 0, no done pulse.
  - Reset deasserting while start is high: start is not accepted until the first rising edge with rst_n high.
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - No sign extension.
  - The chain carry never leaves the block except as co.

Decomposition:
- Shared include file serial_addsub_defs.vh holds the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and a clog2 constant function. It is reused by later multi-cycle arithmetic blocks.
- One sub-module: the existing single-bit full adder, instantiated STEP times in a generate loop to form the chain.
- FSM, counter and shift registers stay in serial_addsub.

Test Plan:
- WIDTH=8, STEP=1, op=0, a=8'h0F, b=8'h01, ci=0 -> busy high 8 cycles, then done pulse with sum=8'h10, co=0, ovf=0.
- op=0, a=8'hFF, b=8'h01, ci=0 -> sum=8'h00, co=1, ovf=0. Then a=8'h7F, b=8'h00, ci=1 -> sum=8'h80, co=0, ovf=1.
- op=1, a=8'h05, b=8'h07, ci=1 (ignored) -> sum=8'hFE, co=0 (borrow), ovf=0. Then a=8'h80, b=8'h01 -> sum=8'h7F, co=1, ovf=1.
- WIDTH=8, STEP=4, a=8'hA5, b=8'h5B, ci=0 -> done exactly 2 cycles after the accept edge, sum=8'h00, co=1. Then start held high in the DONE cycle with a=8'h01, b=8'h01 -> back-to-back run, sum=8'h02.
- Start pulsed in the 3rd RUN cycle with different operands -> ignored; the original result is delivered at the original done time.
- rst_n driven low in the 4th RUN cycle (STEP=1) -> busy/done/sum/co/ovf 0 immediately; no done pulse. A new start after release computes correctly.
